// File: rtl/interrupt_injector.sv
// Interrupt/reset injector: synchronises /NMI and /IRQ, arbitrates at instruction boundaries
// and forces BRK toward control. Optional NMOS-style hijack of IRQ vectors: define NMI_HIJACK_EN.
module interrupt_injector #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  BRK_OPCODE  = 8'h00
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic       nmi_b,
  input  logic       irq_b,
  input  logic [7:0] mem_data,
  input  logic       p_i,
  input  logic       last_cycle,
  input  logic       int_ack,
  output logic [7:0] data_to_ctrl,
  output logic [1:0] vec_sel,
  output logic       int_active,
  output logic       rst_seq
);

  localparam int unsigned SS = (SYNC_STAGES < 32'd2) ? 32'd2 : SYNC_STAGES;

  localparam logic [1:0] VEC_RESET = 2'b00;
  localparam logic [1:0] VEC_NMI   = 2'b01;
  localparam logic [1:0] VEC_IRQ   = 2'b10;

  typedef enum logic [1:0] {
    S_RESET  = 2'b00,
    S_RUN    = 2'b01,
    S_INJECT = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [SS-1:0] nmi_sync_q;
  logic [SS-1:0] irq_sync_q;
  logic          nmi_prev_q;
  logic          nmi_pend_q, nmi_pend_d;
  logic          inject_q, inject_d;
  logic [1:0]    vec_sel_q, vec_sel_d;
  logic          int_active_q, int_active_d;
  logic          rst_seq_q, rst_seq_d;

  logic          nmi_fall_s;
  logic          irq_req_s;
  logic          hijack_s;

  // Pin synchronisers; reset to the inactive (high) level so release never looks like an edge.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_prev_q <= 1'b1;
    end else begin
      nmi_sync_q <= {nmi_sync_q[SS-2:0], nmi_b};
      irq_sync_q <= {irq_sync_q[SS-2:0], irq_b};
      nmi_prev_q <= nmi_sync_q[SS-1];
    end
  end

  assign nmi_fall_s = nmi_prev_q & ~nmi_sync_q[SS-1];
  assign irq_req_s  = ~irq_sync_q[SS-1] & ~p_i;

`ifdef NMI_HIJACK_EN
  assign hijack_s = nmi_fall_s && (state_q == S_INJECT) && (vec_sel_q == VEC_IRQ);
`else
  assign hijack_s = 1'b0;
`endif

  // Sequencer next state: boundary arbitration in S_RUN, hold until int_ack in S_INJECT.
  always_comb begin
    state_d      = state_q;
    inject_d     = 1'b0;
    vec_sel_d    = vec_sel_q;
    int_active_d = int_active_q;
    rst_seq_d    = rst_seq_q;
    nmi_pend_d   = nmi_pend_q | nmi_fall_s;
    case (state_q)
      S_RESET: begin
        state_d      = S_INJECT;
        inject_d     = 1'b1;
        vec_sel_d    = VEC_RESET;
        int_active_d = 1'b1;
        rst_seq_d    = 1'b1;
      end
      S_RUN: begin
        int_active_d = 1'b0;
        rst_seq_d    = 1'b0;
        vec_sel_d    = VEC_IRQ;
        if (last_cycle && nmi_pend_q) begin
          state_d      = S_INJECT;
          inject_d     = 1'b1;
          vec_sel_d    = VEC_NMI;
          int_active_d = 1'b1;
          nmi_pend_d   = 1'b0;
        end else if (last_cycle && irq_req_s) begin
          state_d      = S_INJECT;
          inject_d     = 1'b1;
          vec_sel_d    = VEC_IRQ;
          int_active_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_INJECT: begin
        // int_ack wins over any coincident boundary so one handler instruction always runs.
        if (int_ack) begin
          state_d      = S_RUN;
          vec_sel_d    = VEC_IRQ;
          int_active_d = 1'b0;
          rst_seq_d    = 1'b0;
        end else if (hijack_s) begin
          vec_sel_d  = VEC_NMI;
          nmi_pend_d = 1'b0;
        end else begin
          state_d = S_INJECT;
        end
      end
      default: begin
        state_d      = S_RESET;
        vec_sel_d    = VEC_RESET;
        int_active_d = 1'b1;
        rst_seq_d    = 1'b1;
        nmi_pend_d   = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q      <= S_RESET;
      nmi_pend_q   <= 1'b0;
      inject_q     <= 1'b0;
      vec_sel_q    <= VEC_RESET;
      int_active_q <= 1'b1;
      rst_seq_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      nmi_pend_q   <= nmi_pend_d;
      inject_q     <= inject_d;
      vec_sel_q    <= vec_sel_d;
      int_active_q <= int_active_d;
      rst_seq_q    <= rst_seq_d;
    end
  end

  assign data_to_ctrl = inject_q ? BRK_OPCODE : mem_data;
  assign vec_sel      = vec_sel_q;
  assign int_active   = int_active_q;
  assign rst_seq      = rst_seq_q;

endmodule

// File: tb/tb_interrupt_injector.sv
// Bench for interrupt_injector: directed scenarios plus randomized traffic checked against
// an event-level reference model. Honours NMI_HIJACK_EN when defined for the build.
module tb_interrupt_injector;

  localparam int unsigned SS  = 2;
  localparam logic [7:0]  BRK = 8'h00;

  logic       ph1;
  logic       reset;
  logic       nmi_b;
  logic       irq_b;
  logic [7:0] mem_data;
  logic       p_i;
  logic       last_cycle;
  logic       int_ack;
  logic [7:0] data_to_ctrl;
  logic [1:0] vec_sel;
  logic       int_active;
  logic       rst_seq;

  int n_cmp = 0;
  int n_err = 0;

  interrupt_injector #(.SYNC_STAGES(SS), .BRK_OPCODE(BRK)) dut (
    .ph1(ph1), .reset(reset), .nmi_b(nmi_b), .irq_b(irq_b), .mem_data(mem_data),
    .p_i(p_i), .last_cycle(last_cycle), .int_ack(int_ack), .data_to_ctrl(data_to_ctrl),
    .vec_sel(vec_sel), .int_active(int_active), .rst_seq(rst_seq)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  wire [11:0] obs = {data_to_ctrl, vec_sel, int_active, rst_seq};

  // Reference model: pin history (index 0 = newest sample) and handler bookkeeping.
  logic [SS:0] m_nmi_hist;
  logic [SS:0] m_irq_hist;
  bit          m_wait_release;
  bit          m_in_seq;
  bit          m_is_rst;
  bit          m_inject;
  bit          m_pend;
  int          m_vec;

  task automatic model_reset();
    m_nmi_hist     = '1;
    m_irq_hist     = '1;
    m_wait_release = 1'b1;
    m_in_seq       = 1'b1;
    m_is_rst       = 1'b1;
    m_inject       = 1'b0;
    m_pend         = 1'b0;
    m_vec          = 0;
  endtask

  task automatic model_step();
    bit nmi_edge;
    bit irq_want;
    nmi_edge = m_nmi_hist[SS] && !m_nmi_hist[SS-1];
    irq_want = !m_irq_hist[SS-1] && !p_i;
    m_inject = 1'b0;
    if (reset) begin
      model_reset();
    end else begin
      if (m_wait_release) begin
        m_wait_release = 1'b0;
        m_inject       = 1'b1;
        m_pend         = m_pend || nmi_edge;
      end else if (m_in_seq) begin
        if (int_ack) begin
          m_in_seq = 1'b0;
          m_is_rst = 1'b0;
          m_vec    = 2;
          m_pend   = m_pend || nmi_edge;
`ifdef NMI_HIJACK_EN
        end else if (m_vec == 2 && nmi_edge) begin
          m_vec  = 1;
          m_pend = 1'b0;
`endif
        end else begin
          m_pend = m_pend || nmi_edge;
        end
      end else if (last_cycle && m_pend) begin
        m_in_seq = 1'b1;
        m_inject = 1'b1;
        m_vec    = 1;
        m_pend   = 1'b0;
      end else if (last_cycle && irq_want) begin
        m_in_seq = 1'b1;
        m_inject = 1'b1;
        m_vec    = 2;
        m_pend   = m_pend || nmi_edge;
      end else begin
        m_pend = m_pend || nmi_edge;
      end
      m_nmi_hist = {m_nmi_hist[SS-1:0], nmi_b};
      m_irq_hist = {m_irq_hist[SS-1:0], irq_b};
    end
  endtask

  function automatic logic [11:0] model_exp();
    logic [7:0] d;
    logic [1:0] v;
    d = m_inject ? BRK : mem_data;
    v = 2'(m_vec);
    return {d, v, m_in_seq, m_is_rst};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ph1);
      model_step();
      #1;
    end
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b1;
    model_reset();
    tick(2);
    exp = {8'hEA, 2'b00, 1'b1, 1'b1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_hold_in: got %h want %h", obs, exp); end
    reset = 1'b0;
    tick(1);
    exp = {8'h00, 2'b00, 1'b1, 1'b1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_inject: got %h want %h", obs, exp); end
    tick(3);
    exp = {8'hEA, 2'b00, 1'b1, 1'b1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_seq_hold: got %h want %h", obs, exp); end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    exp = {8'hEA, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_exit: got %h want %h", obs, exp); end
    mem_data = 8'h5C;
    #1;
    exp = {8'h5C, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL passthrough: got %h want %h", obs, exp); end
    mem_data = 8'hEA;
  endtask

  task automatic test_irq();
    logic [11:0] exp;
    irq_b = 1'b0;
    tick(3);
    last_cycle = 1'b1;
    tick(1);
    last_cycle = 1'b0;
    exp = {8'h00, 2'b10, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL irq_inject: got %h want %h", obs, exp); end
    tick(1);
    exp = {8'hEA, 2'b10, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL irq_one_cycle: got %h want %h", obs, exp); end
    irq_b = 1'b1;
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    exp = {8'hEA, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL irq_exit: got %h want %h", obs, exp); end
    p_i = 1'b1;
    irq_b = 1'b0;
    tick(3);
    last_cycle = 1'b1;
    mem_data = 8'h3B;
    tick(1);
    exp = {8'h3B, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL irq_masked: got %h want %h", obs, exp); end
    mem_data = 8'hC4;
    tick(1);
    exp = {8'hC4, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL irq_masked2: got %h want %h", obs, exp); end
    last_cycle = 1'b0;
    irq_b = 1'b1;
    p_i = 1'b0;
    mem_data = 8'hEA;
    tick(3);
  endtask

  task automatic test_priority();
    logic [11:0] exp;
    nmi_b = 1'b0;
    irq_b = 1'b0;
    tick(4);
    last_cycle = 1'b1;
    tick(1);
    exp = {8'h00, 2'b01, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL nmi_over_irq: got %h want %h", obs, exp); end
    tick(2);
    exp = {8'hEA, 2'b01, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL inject_ignores_boundary: got %h want %h", obs, exp); end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    exp = {8'hEA, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL ack_with_boundary: got %h want %h", obs, exp); end
    tick(1);
    exp = {8'h00, 2'b10, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL irq_after_nmi: got %h want %h", obs, exp); end
    last_cycle = 1'b0;
    irq_b = 1'b1;
    nmi_b = 1'b1;
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    tick(3);
  endtask

  task automatic test_nmi_single();
    logic [11:0] exp;
    nmi_b = 1'b0;
    tick(3);
    nmi_b = 1'b1;
    tick(10);
    last_cycle = 1'b1;
    tick(1);
    last_cycle = 1'b0;
    exp = {8'h00, 2'b01, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL nmi_pulse_inject: got %h want %h", obs, exp); end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    exp = {8'hEA, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL nmi_pulse_exit: got %h want %h", obs, exp); end
    last_cycle = 1'b1;
    tick(1);
    last_cycle = 1'b0;
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL nmi_no_second: got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    nmi_b = 1'b0;
    tick(3);
    last_cycle = 1'b1;
    tick(1);
    last_cycle = 1'b0;
    exp = {8'h00, 2'b01, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mid_nmi_inject: got %h want %h", obs, exp); end
    nmi_b = 1'b1;
    tick(3);
    nmi_b = 1'b0;
    tick(3);
    nmi_b = 1'b1;
    reset = 1'b1;
    model_reset();
    #1;
    exp = {8'hEA, 2'b00, 1'b1, 1'b1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_async: got %h want %h", obs, exp); end
    tick(2);
    reset = 1'b0;
    tick(1);
    exp = {8'h00, 2'b00, 1'b1, 1'b1};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mid_reset_inject: got %h want %h", obs, exp); end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    last_cycle = 1'b1;
    tick(1);
    last_cycle = 1'b0;
    exp = {8'hEA, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL reset_clears_pend: got %h want %h", obs, exp); end
  endtask

  task automatic test_hijack();
    logic [11:0] exp;
    irq_b = 1'b0;
    tick(3);
    last_cycle = 1'b1;
    tick(1);
    last_cycle = 1'b0;
    exp = {8'h00, 2'b10, 1'b1, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL hj_irq_inject: got %h want %h", obs, exp); end
    tick(1);
    nmi_b = 1'b0;
    irq_b = 1'b1;
    tick(3);
`ifdef NMI_HIJACK_EN
    exp = {8'hEA, 2'b01, 1'b1, 1'b0};
`else
    exp = {8'hEA, 2'b10, 1'b1, 1'b0};
`endif
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL hj_vector: got %h want %h", obs, exp); end
    tick(1);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    exp = {8'hEA, 2'b10, 1'b0, 1'b0};
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL hj_exit: got %h want %h", obs, exp); end
    last_cycle = 1'b1;
    tick(1);
    last_cycle = 1'b0;
`ifdef NMI_HIJACK_EN
    exp = {8'hEA, 2'b10, 1'b0, 1'b0};
`else
    exp = {8'h00, 2'b01, 1'b1, 1'b0};
`endif
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL hj_followup: got %h want %h", obs, exp); end
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    nmi_b = 1'b1;
    tick(3);
  endtask

  task automatic test_random();
    logic [11:0] exp;
    reset = 1'b1;
    model_reset();
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      mem_data = 8'($urandom);
      if ($urandom_range(7, 0) == 0) nmi_b = ~nmi_b;
      if ($urandom_range(9, 0) == 0) irq_b = ~irq_b;
      if ($urandom_range(15, 0) == 0) p_i = ~p_i;
      last_cycle = ($urandom_range(3, 0) == 0);
      int_ack = ($urandom_range(4, 0) == 0);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(399, 0) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        exp = model_exp();
        n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rand_async_reset: cycle %0d got %h want %h", i, obs, exp); end
      end
      tick(1);
      exp = model_exp();
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rand_cycle: cycle %0d got %h want %h", i, obs, exp); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    nmi_b      = 1'b1;
    irq_b      = 1'b1;
    mem_data   = 8'hEA;
    p_i        = 1'b0;
    last_cycle = 1'b0;
    int_ack    = 1'b0;
    model_reset();
    test_reset();
    test_irq();
    test_priority();
    test_nmi_single();
    test_reset_mid();
    test_hijack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_injector.md
Name: interrupt_injector

Overview:
- Sits directly upstream of the control FSM, between the memory data bus and the control unit's opcode input (data_in).
- Synchronises /NMI and /IRQ, arbitrates them at instruction boundaries, and injects a forced BRK opcode so that control runs its BRK microcode sequence for interrupts and reset.
- Drives the vector select consumed by the address-generation path, plus an interrupt-active flag. Control uses that flag to suppress the PC increment and the B-flag push.

Parameters:
- SYNC_STAGES, 2, flop depth of the nmi_b/irq_b synchronisers (min 2).
- BRK_OPCODE, 8'h00, opcode byte injected toward control.

Ports:
- ph1  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- nmi_b  input  1  async external NMI, active-low, falling-edge sensitive.
- irq_b  input  1  async external IRQ, active-low, level sensitive.
- mem_data  input  8  byte from the memory data bus.
- p_i  input  1  I (interrupt-disable) flag from status register.
- last_cycle  input  1  control: current cycle is the final cycle of the instruction.
- int_ack  input  1  control: one-cycle pulse on the final cycle of the BRK/vector-fetch sequence.
- data_to_ctrl  output  8  opcode/data byte feeding control's data_in.
- vec_sel  output  2  vector: 00 RESET $FFFC, 01 NMI $FFFA, 10 IRQ/BRK $FFFE.
- int_active  output  1  a hardware-injected sequence is in progress.
- rst_seq  output  1  the in-progress sequence is the reset sequence.

Behaviour:
- Interface: one clock (ph1); reset is asynchronous and active-high.
- Reset (async, any time, including mid-sequence), all of the following:
  - State goes to S_RESET.
  - Synchroniser flops set to 1 (inactive); nmi_pend cleared.
  - inject is 0; vec_sel is 00; int_active is 1; rst_seq is 1.
- data_to_ctrl = inject ? BRK_OPCODE : mem_data. This is combinational, with zero latency in pass-through.
- NMI edge: a synchronised 1->0 transition of nmi_b sets nmi_pend.
  - nmi_pend clears only when the NMI is accepted.
  - A second edge while nmi_pend is set is absorbed (no counting).
  - A level held low produces exactly one edge.
- IRQ request is irq_req = synchronised irq_b == 0 && !p_i. It is not latched, so deassertion before the boundary drops it.
- States:
  - S_RESET, on the first edge after reset deasserts: go to S_INJECT. Set inject=1 for one cycle, vec_sel=00, int_active=1.
  - S_RUN: int_active=0, rst_seq=0, vec_sel=10 (so software BRK vectors via $FFFE). On a cycle with last_cycle=1:
    - If nmi_pend: go to S_INJECT, set vec_sel=01, clear nmi_pend.
    - Else if irq_req: go to S_INJECT, set vec_sel=10.
    - Else: stay in S_RUN.
    - On either accept, inject=1 in the next cycle only, which is control's opcode-fetch cycle, and int_active=1.
  - S_INJECT: hold vec_sel and int_active. last_cycle is ignored for arbitration. On int_ack go to S_RUN. int_active and rst_seq drop in the cycle after int_ack.
- Priority at a boundary: NMI over IRQ.
- int_ack coinciding with last_cycle: return to S_RUN with no acceptance that cycle. At least one handler instruction therefore completes before any further interrupt is taken.
- An NMI edge arriving during S_INJECT or S_RESET stays pending and is serviced at the first boundary in S_RUN.
- int_ack in S_RUN is ignored.

Optional Feature:
- Macro NMI_HIJACK_EN.
- Defined: an NMI edge that is synchronised while in S_INJECT with vec_sel=10, before int_ack, does three things:
  - switches vec_sel to 01 on the next cycle;
  - clears nmi_pend;
  - leaves int_active unchanged.
  - The IRQ is lost, matching NMOS 6502 hijack behaviour.
- Undefined: the vector is fixed at acceptance and the NMI waits for the next boundary.

Test Plan:
- Reset released, mem_data=8'hEA -> data_to_ctrl=8'h00 on the first cycle after release.
  - vec_sel=00, int_active=1, rst_seq=1 until int_ack.
  - The cycle after int_ack: int_active=0, vec_sel=10, data_to_ctrl=8'hEA.
- irq_b=0 with p_i=0, last_cycle pulsed -> next cycle data_to_ctrl=8'h00, vec_sel=10, int_active=1.
  - Repeat with p_i=1 -> no injection; data_to_ctrl tracks mem_data.
- nmi_b and irq_b fall together, boundary after synchronisation -> vec_sel=01. The IRQ is taken at the first boundary after int_ack, provided irq_b is still 0.
- nmi_b pulsed low 3 cycles then high, boundary 10 cycles later -> exactly one NMI injection; no second injection at the following boundary.
- Reset asserted mid-S_INJECT (vec_sel=01) -> immediately vec_sel=00, int_active=1, rst_seq=1, nmi_pend cleared.
  - After release, one reset injection and no NMI.
- NMI_HIJACK_EN: IRQ accepted, NMI edge 2 cycles later, int_ack 6 cycles later -> vec_sel goes 10 to 01 before int_ack; no NMI injection afterwards.
  - Without the macro: vec_sel stays 10 and the NMI is injected at the next boundary.
